mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core101_mem_pkg.sv | 13 +
 rtl/mem_arb_grant.sv | 22 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_mem_pkg.sv
// Shared constants for the core101 memory arbiter: FSM encoding,
// source select values and the opcode driven for instruction fetches.
package core101_mem_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic SEL_INS  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  localparam logic [2:0] OP_INS_FETCH = 3'b010;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the arbiter: turns the two request valids and the
// last granted source into a one-hot grant.
// Ports: ins_valid_i, data_valid_i, last_grant_i -> grant_ins_o, grant_data_o.
module mem_arb_grant
  import core101_mem_pkg::*;
(
  input  logic ins_valid_i,
  input  logic data_valid_i,
  input  logic last_grant_i,
  output logic grant_ins_o,
  output logic grant_data_o
);

  // On contention the source not granted last time wins; a last_grant
  // tied to SEL_INS therefore gives data fixed priority.
  always_comb begin
    grant_data_o = data_valid_i &
                   (~ins_valid_i | (last_grant_i == SEL_INS));
    grant_ins_o  = ins_valid_i & ~grant_data_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-source (fetch / load-store) arbiter in front of one shared memory port.
// Ports: clock_in, reset_in; ins_req_*/ins_resp_*; data_req_*/data_resp_*;
// mem_* request out, mem_ready_in/mem_data_in completion in.
// Build option MEM_ARB_RR_EN: round-robin on contention instead of
// fixed data-over-fetch priority.
module mem_arbiter
  import core101_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    ins_req_valid_in,
  input  logic [DATA_WIDTH-1:0]   ins_req_addr_in,
  output logic                    ins_req_ready_out,
  output logic                    ins_resp_valid_out,
  output logic [DATA_WIDTH-1:0]   ins_resp_data_out,
  input  logic                    data_req_valid_in,
  input  logic [OPCODE_WIDTH-1:0] data_req_opcode_in,
  input  logic [DATA_WIDTH-1:0]   data_req_addr_in,
  input  logic [DATA_WIDTH-1:0]   data_req_data_in,
  output logic                    data_req_ready_out,
  output logic                    data_resp_valid_out,
  output logic [DATA_WIDTH-1:0]   data_resp_data_out,
  output logic                    mem_valid_out,
  output logic                    mem_sel_out,
  output logic [OPCODE_WIDTH-1:0] mem_opcode_out,
  output logic [DATA_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_in
);

  logic [0:0]              state_q, state_d;
  logic                    sel_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q;
  logic                    irv_q, drv_q;
  logic [DATA_WIDTH-1:0]   ird_q, drd_q;
  logic                    g_ins, g_data;
  logic                    last_grant;
  logic                    idle, accept, done;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      last_grant_q <= SEL_DATA;
    end else if (accept) begin
      last_grant_q <= g_data ? SEL_DATA : SEL_INS;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = SEL_INS;
`endif

  mem_arb_grant u_grant (
    .ins_valid_i  (ins_req_valid_in),
    .data_valid_i (data_req_valid_in),
    .last_grant_i (last_grant),
    .grant_ins_o  (g_ins),
    .grant_data_o (g_data)
  );

  // Ready is gated by reset so it drops while reset is held.
  assign idle   = (state_q == IDLE) & ~reset_in;
  assign ins_req_ready_out  = idle & g_ins;
  assign data_req_ready_out = idle & g_data;
  assign accept = ins_req_ready_out | data_req_ready_out;
  // mem_ready_in only counts while a request is on the bus.
  assign done   = (state_q == BUSY) & mem_ready_in;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = BUSY;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      sel_q   <= SEL_INS;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      irv_q   <= 1'b0;
      drv_q   <= 1'b0;
      ird_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      irv_q   <= done & (sel_q == SEL_INS);
      drv_q   <= done & (sel_q == SEL_DATA);
      if (accept) begin
        sel_q   <= g_data ? SEL_DATA : SEL_INS;
        op_q    <= g_data ? data_req_opcode_in
                          : OPCODE_WIDTH'(OP_INS_FETCH);
        addr_q  <= g_data ? data_req_addr_in : ins_req_addr_in;
        wdata_q <= g_data ? data_req_data_in : '0;
      end
      if (done && sel_q == SEL_INS) begin
        ird_q <= mem_data_in;
      end
      if (done && sel_q == SEL_DATA) begin
        drd_q <= mem_data_in;
      end
    end
  end

  assign mem_valid_out       = (state_q == BUSY);
  assign mem_sel_out         = sel_q;
  assign mem_opcode_out      = op_q;
  assign mem_addr_out        = addr_q;
  assign mem_data_out        = wdata_q;
  assign ins_resp_valid_out  = irv_q;
  assign ins_resp_data_out   = ird_q;
  assign data_resp_valid_out = drv_q;
  assign data_resp_data_out  = drd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cycle table, multi-cycle
// corner sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, dv, ir, dr, irv, drv, mv, msel, mr;
  logic [31:0] ia, da, dd, ird, drd, ma, md_o, md_i;
  logic [2:0]  dop, mop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .OPCODE_WIDTH(3)) dut (
    .clock_in            (clk),
    .reset_in            (rst),
    .ins_req_valid_in    (iv),
    .ins_req_addr_in     (ia),
    .ins_req_ready_out   (ir),
    .ins_resp_valid_out  (irv),
    .ins_resp_data_out   (ird),
    .data_req_valid_in   (dv),
    .data_req_opcode_in  (dop),
    .data_req_addr_in    (da),
    .data_req_data_in    (dd),
    .data_req_ready_out  (dr),
    .data_resp_valid_out (drv),
    .data_resp_data_out  (drd),
    .mem_valid_out       (mv),
    .mem_sel_out         (msel),
    .mem_opcode_out      (mop),
    .mem_addr_out        (ma),
    .mem_data_out        (md_o),
    .mem_ready_in        (mr),
    .mem_data_in         (md_i)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic i_v, logic [31:0] i_a, logic d_v,
                       logic [2:0] d_op, logic [31:0] d_a,
                       logic [31:0] d_d, logic m_r, logic [31:0] m_d);
    iv = i_v; ia = i_a; dv = d_v; dop = d_op;
    da = d_a; dd = d_d; mr = m_r; md_i = m_d;
  endtask

  typedef struct {
    logic iv; logic [31:0] ia;
    logic dv; logic [2:0] dop; logic [31:0] da, dd;
    logic mr; logic [31:0] md;
    logic e_ir, e_dr, e_mv, e_sel;
    logic [2:0] e_op; logic [31:0] e_ma, e_md;
    logic e_irv; logic [31:0] e_ird;
    logic e_drv; logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic i_v, logic [31:0] i_a, logic d_v,
                     logic [2:0] d_op, logic [31:0] d_a, logic [31:0] d_d,
                     logic m_r, logic [31:0] m_d,
                     logic e_ir, logic e_dr, logic e_mv, logic e_sel,
                     logic [2:0] e_op, logic [31:0] e_ma, logic [31:0] e_md,
                     logic e_irv, logic [31:0] e_ird,
                     logic e_drv, logic [31:0] e_drd);
    vec_t v;
    v.iv = i_v; v.ia = i_a; v.dv = d_v; v.dop = d_op;
    v.da = d_a; v.dd = d_d; v.mr = m_r; v.md = m_d;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_mv = e_mv; v.e_sel = e_sel;
    v.e_op = e_op; v.e_ma = e_ma; v.e_md = e_md;
    v.e_irv = e_irv; v.e_ird = e_ird;
    v.e_drv = e_drv; v.e_drd = e_drd;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h1, 1, 3'd1, 32'h2, 32'h3, 1, 32'h4);
    #1;
    chk("rst_ir", {31'd0, ir}, 0);
    chk("rst_dr", {31'd0, dr}, 0);
    chk("rst_mv", {31'd0, mv}, 0);
    @(negedge clk);
    chk("rst_sel", {31'd0, msel}, 0);
    chk("rst_irv", {31'd0, irv}, 0);
    chk("rst_drv", {31'd0, drv}, 0);
    chk("rst_op", {29'd0, mop}, 0);
    chk("rst_ma", ma, 0);
    chk("rst_md", md_o, 0);
    chk("rst_ird", ird, 0);
    chk("rst_drd", drd, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Transaction-level reference model
  typedef struct {
    logic sel; logic [2:0] op; logic [31:0] a, d;
  } txn_t;

  txn_t        pend[$];
  logic        m_irv, m_drv, m_last_data;
  logic [31:0] m_ird, m_drd;

  task automatic model_reset();
    pend.delete();
    m_irv = 0; m_drv = 0; m_ird = 0; m_drd = 0;
    m_last_data = 1;
  endtask

  task automatic model_cycle();
    logic gi, gd;
    txn_t t;
    gi = 0; gd = 0;
    if (pend.size() == 0) begin
      if (iv && dv) begin
`ifdef MEM_ARB_RR_EN
        gd = !m_last_data;
`else
        gd = 1;
`endif
        gi = !gd;
      end else begin
        gi = iv;
        gd = dv;
      end
    end
    chk("m_ir", {31'd0, ir}, {31'd0, gi});
    chk("m_dr", {31'd0, dr}, {31'd0, gd});
    chk("m_mv", {31'd0, mv}, {31'd0, pend.size() != 0});
    chk("m_irv", {31'd0, irv}, {31'd0, m_irv});
    chk("m_drv", {31'd0, drv}, {31'd0, m_drv});
    chk("m_ird", ird, m_ird);
    chk("m_drd", drd, m_drd);
    if (pend.size() != 0) begin
      chk("m_sel", {31'd0, msel}, {31'd0, pend[0].sel});
      chk("m_op", {29'd0, mop}, {29'd0, pend[0].op});
      chk("m_ma", ma, pend[0].a);
      if (pend[0].sel) chk("m_md", md_o, pend[0].d);
    end
    m_irv = 0;
    m_drv = 0;
    if (pend.size() != 0) begin
      if (mr) begin
        t = pend.pop_front();
        if (t.sel) begin m_drv = 1; m_drd = md_i; end
        else begin m_irv = 1; m_ird = md_i; end
      end
    end else if (gi || gd) begin
      t.sel = gd;
      t.op  = gd ? dop : 3'b010;
      t.a   = gd ? da : ia;
      t.d   = dd;
      pend.push_back(t);
      m_last_data = gd;
    end
  endtask

  initial begin
    logic [31:0] D;
    logic [31:0] BE;
    logic [31:0] R1;
    D  = 32'h00500093;
    BE = 32'hDEADBEEF;
    R1 = 32'h12345678;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // fetch, store with waits, contention, idle ready, back-to-back fetches
    add(1,32'h10,0,0,0,0,0,0,          1,0,0,0,0,0,0,   0,0, 0,0);
    add(0,0,0,0,0,0,1,D,               0,0,1,0,2,32'h10,0, 0,0, 0,0);
    add(0,0,0,0,0,0,0,0,               0,0,0,0,0,0,0,   1,D, 0,0);
    add(1,32'h10,1,2,32'h20,BE,0,0,    0,1,0,0,0,0,0,   0,D, 0,0);
    add(1,32'h10,0,0,0,0,0,0,          0,0,1,1,2,32'h20,BE, 0,D, 0,0);
    add(1,32'h10,0,0,0,0,0,0,          0,0,1,1,2,32'h20,BE, 0,D, 0,0);
    add(1,32'h10,0,0,0,0,0,0,          0,0,1,1,2,32'h20,BE, 0,D, 0,0);
    add(1,32'h10,0,0,0,0,1,R1,         0,0,1,1,2,32'h20,BE, 0,D, 0,0);
    add(1,32'h10,0,0,0,0,0,0,          1,0,0,0,0,0,0,   0,D, 1,R1);
    add(0,0,0,0,0,0,1,32'hA,           0,0,1,0,2,32'h10,0, 0,D, 0,R1);
    add(0,0,0,0,0,0,1,32'hFF,          0,0,0,0,0,0,0,   1,32'hA, 0,R1);
    add(0,0,0,0,0,0,1,32'hEE,          0,0,0,0,0,0,0,   0,32'hA, 0,R1);
    add(1,32'h0,0,0,0,0,1,32'hDD,      1,0,0,0,0,0,0,   0,32'hA, 0,R1);
    add(1,32'h4,0,0,0,0,1,32'h11,      0,0,1,0,2,32'h0,0, 0,32'hA, 0,R1);
    add(1,32'h4,0,0,0,0,1,32'h33,      1,0,0,0,0,0,0,   1,32'h11, 0,R1);
    add(0,0,0,0,0,0,1,32'h22,          0,0,1,0,2,32'h4,0, 0,32'h11, 0,R1);
    add(0,0,0,0,0,0,0,0,               0,0,0,0,0,0,0,   1,32'h22, 0,R1);

    do_reset();
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].dop,
            vecs[i].da, vecs[i].dd, vecs[i].mr, vecs[i].md);
      #1;
      chk($sformatf("v%0d_ir", i), {31'd0, ir}, {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_dr", i), {31'd0, dr}, {31'd0, vecs[i].e_dr});
      chk($sformatf("v%0d_mv", i), {31'd0, mv}, {31'd0, vecs[i].e_mv});
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d_sel", i), {31'd0, msel}, {31'd0, vecs[i].e_sel});
        chk($sformatf("v%0d_op", i), {29'd0, mop}, {29'd0, vecs[i].e_op});
        chk($sformatf("v%0d_ma", i), ma, vecs[i].e_ma);
        if (vecs[i].e_sel)
          chk($sformatf("v%0d_md", i), md_o, vecs[i].e_md);
      end
      chk($sformatf("v%0d_irv", i), {31'd0, irv}, {31'd0, vecs[i].e_irv});
      chk($sformatf("v%0d_ird", i), ird, vecs[i].e_ird);
      chk($sformatf("v%0d_drv", i), {31'd0, drv}, {31'd0, vecs[i].e_drv});
      chk($sformatf("v%0d_drd", i), drd, vecs[i].e_drd);
    end

    // contention right after reset
    do_reset();
    drive(1, 32'h100, 1, 3'd3, 32'h200, 32'h5, 0, 0);
    #1;
`ifdef MEM_ARB_RR_EN
    chk("c1_ir", {31'd0, ir}, 1);
    chk("c1_dr", {31'd0, dr}, 0);
`else
    chk("c1_ir", {31'd0, ir}, 0);
    chk("c1_dr", {31'd0, dr}, 1);
`endif
    @(negedge clk);
    drive(1, 32'h100, 1, 3'd3, 32'h200, 32'h5, 1, 32'h9);
    #1;
`ifdef MEM_ARB_RR_EN
    chk("c1_sel", {31'd0, msel}, 0);
`else
    chk("c1_sel", {31'd0, msel}, 1);
`endif
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    drive(1, 32'h100, 1, 3'd3, 32'h200, 32'h5, 0, 0);
    #1;
    chk("c2_ir", {31'd0, ir}, 0);
    chk("c2_dr", {31'd0, dr}, 1);
`else
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    #1;
    chk("c2_ir", {31'd0, ir}, 1);
    chk("c2_dr", {31'd0, dr}, 0);
`endif

    // reset while busy
    do_reset();
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rb_mv_before", {31'd0, mv}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_mv_drop", {31'd0, mv}, 0);
    mr = 1'b1;
    md_i = 32'h77;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h44, 0, 0, 0, 0, 1, 32'h77);
    #1;
    chk("rb_accept", {31'd0, ir}, 1);
    chk("rb_irv0", {31'd0, irv}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rb_irv1", {31'd0, irv}, 0);
    chk("rb_ma", ma, 32'h44);

    // random traffic vs model
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            3'($urandom), $urandom, $urandom,
            ($urandom_range(0, 2) == 0), $urandom);
      #1;
      model_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
